// File: rtl/clause_array_loader_pkg.sv
// clause_array_loader_pkg: sequencer state encoding, default array geometry and
// width helpers shared by the loader and its decoder.
package clause_array_loader_pkg;
  localparam int DEF_NUM_VARS = 8;
  localparam int DEF_NUM_CLAUSES = 8;
  localparam int DEF_WIDTH_C_LEN = 4;
  localparam int PTR_W = $clog2(DEF_NUM_CLAUSES + 1);
  localparam int IDX_W = $clog2(DEF_NUM_CLAUSES);
  typedef enum logic [2:0] {IDLE, LOAD, FILL, RD, OUT, FIN} state_t;
  function automatic int ptr_w(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clause_array_loader_onehot_dec.sv
// onehot_dec: slot pointer to a one-hot slot strobe, all zero when en is low.
module onehot_dec #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic [W-1:0] idx,
  input  logic         en,
  output logic [N-1:0] oh
);
  always_comb oh = en ? N'(1) << idx : '0;
endmodule

// File: rtl/clause_array_loader.sv
// clause_array_loader: load/unload sequencer between the clause stream and one
// clause array bank; loads walk the slots with wr strobes, unloads with rd strobes.
module clause_array_loader
  import clause_array_loader_pkg::*;
#(
  parameter int NUM_VARS = DEF_NUM_VARS,
  parameter int NUM_CLAUSES = DEF_NUM_CLAUSES,
  parameter int WIDTH_C_LEN = DEF_WIDTH_C_LEN,
  localparam int CW = NUM_VARS * 2,
  localparam int PW = ptr_w(NUM_CLAUSES),
  localparam int IW = idx_w(NUM_CLAUSES)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_start_i,
  input  logic                               unload_start_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [CW-1:0]                      in_clause_i,
  input  logic [WIDTH_C_LEN-1:0]             in_len_i,
  input  logic                               in_last_i,
  output logic [NUM_CLAUSES-1:0]             wr_o,
  output logic [NUM_CLAUSES-1:0]             rd_o,
  output logic [CW-1:0]                      clause_o,
  output logic [WIDTH_C_LEN-1:0]             clause_len_o,
  input  logic [CW-1:0]                      clause_i,
  input  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] clause_len_arr_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [CW-1:0]                      out_clause_o,
  output logic [WIDTH_C_LEN-1:0]             out_len_o,
  output logic [IW-1:0]                      out_idx_o,
  output logic [PW-1:0]                      num_loaded_o,
  output logic                               busy_o,
  output logic                               done_o
);
  state_t state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt, nl_nxt;
  logic [NUM_CLAUSES-1:0] wr_nxt, rd_nxt;
  logic beat, wr_en, rd_en;
  assign in_ready_o = state == LOAD;
  assign busy_o = state != IDLE;
  assign done_o = state == FIN;
  assign beat = state == LOAD && in_valid_i;
  assign wr_en = beat || state == FILL;
  assign rd_en = state == RD;
  onehot_dec #(.N(NUM_CLAUSES), .W(PW)) u_wr_dec (.idx(ptr), .en(wr_en), .oh(wr_nxt));
  onehot_dec #(.N(NUM_CLAUSES), .W(PW)) u_rd_dec (.idx(ptr), .en(rd_en), .oh(rd_nxt));
  always_comb begin
    state_nxt = state;
    ptr_nxt = ptr;
    nl_nxt = num_loaded_o;
    case (state)
      IDLE: begin
        if (load_start_i || unload_start_i) ptr_nxt = '0;
        if (load_start_i) nl_nxt = '0;
        state_nxt = load_start_i ? LOAD : !unload_start_i ? IDLE : num_loaded_o == '0 ? FIN : RD;
      end
      LOAD: if (in_valid_i) begin
        ptr_nxt = ptr + PW'(1);
        nl_nxt = num_loaded_o + PW'(1);
        if (in_last_i || ptr == PW'(NUM_CLAUSES - 1))
          state_nxt = ptr_nxt < PW'(NUM_CLAUSES) ? FILL : FIN;
      end
      FILL: begin
        ptr_nxt = ptr + PW'(1);
        if (ptr == PW'(NUM_CLAUSES - 1)) state_nxt = FIN;
      end
      RD: state_nxt = OUT;
      OUT: if (out_valid_o && out_ready_i) begin
        ptr_nxt = ptr + PW'(1);
        state_nxt = ptr_nxt == num_loaded_o ? FIN : RD;
      end
      FIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // The array answers a rd strobe combinationally, so the beat is captured
  // at the end of the cycle in which rd_o is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      num_loaded_o <= '0;
      wr_o <= '0;
      rd_o <= '0;
      clause_o <= '0;
      clause_len_o <= '0;
      out_valid_o <= 1'b0;
      out_clause_o <= '0;
      out_len_o <= '0;
      out_idx_o <= '0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      num_loaded_o <= nl_nxt;
      wr_o <= wr_nxt;
      rd_o <= rd_nxt;
      clause_o <= beat ? in_clause_i : '0;
      clause_len_o <= beat ? in_len_i : '0;
      if (state == OUT && rd_o != '0) begin
        out_valid_o <= 1'b1;
        out_clause_o <= clause_i;
        out_len_o <= clause_len_arr_i[ptr[IW-1:0]*WIDTH_C_LEN +: WIDTH_C_LEN];
        out_idx_o <= ptr[IW-1:0];
      end else if (out_valid_o && out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: doc/clause_array_loader.md
Name: clause_array_loader

Overview:
- Load/unload sequencer for one clause array bank in the SAT engine.
- Load direction: accepts a valid/ready clause stream and writes each clause into the next slot with a one-hot wr pulse. Slots left unused after the last clause are cleared with zero clauses.
- Unload direction: sweeps the loaded slots with one-hot rd pulses and returns each clause and its reported length on a valid/ready output stream.
- Sits between the clause buffer/host interface and the clause array's wr_i/rd_i/clause_i/clause_o/clause_len_o interface.

Parameters:
NUM_VARS, 8, variables per clause; each literal is 2 bits
NUM_CLAUSES, 8, clause slots in the array
WIDTH_C_LEN, 4, width of a clause length field

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
load_start_i  in  1  start a load pass (sampled only in IDLE)
unload_start_i  in  1  start an unload pass (sampled only in IDLE)
in_valid_i  in  1  input clause beat valid
in_ready_o  out  1  loader accepts a beat
in_clause_i  in  NUM_VARS*2  input clause literals
in_len_i  in  WIDTH_C_LEN  input clause length
in_last_i  in  1  final clause of the pass
wr_o  out  NUM_CLAUSES  one-hot slot write strobe to the array
rd_o  out  NUM_CLAUSES  one-hot slot read strobe to the array
clause_o  out  NUM_VARS*2  clause data to the array
clause_len_o  out  WIDTH_C_LEN  clause length to the array
clause_i  in  NUM_VARS*2  OR of all array clause outputs; unselected slots drive 0
clause_len_arr_i  in  WIDTH_C_LEN*NUM_CLAUSES  per-slot lengths; slot k is at [k*W +: W]
out_valid_o  out  1  unload beat valid
out_ready_i  in  1  downstream accepts the beat
out_clause_o  out  NUM_VARS*2  unloaded clause
out_len_o  out  WIDTH_C_LEN  unloaded length; 0 means the slot is empty or reason-locked
out_idx_o  out  $clog2(NUM_CLAUSES)  slot index of the beat
num_loaded_o  out  $clog2(NUM_CLAUSES+1)  clauses written by the last load pass
busy_o  out  1  state is not IDLE
done_o  out  1  one-cycle pulse when a pass completes

Behaviour:
- Reset (rst==0 at posedge): state IDLE; ptr=0; num_loaded_o=0; all outputs 0.
- All array-side outputs (wr_o, rd_o, clause_o, clause_len_o) are registered.
- States: IDLE, LOAD, FILL, RD, OUT, FIN.
- IDLE:
  - load_start_i -> LOAD with ptr=0 and num_loaded cleared.
  - unload_start_i -> RD with ptr=0, but if num_loaded_o==0 go directly to FIN.
  - Both starts asserted together: load wins.
- LOAD:
  - in_ready_o=1.
  - A beat is accepted at cycle T when in_valid_i && in_ready_o. At T+1: wr_o=1<<ptr, clause_o=in_clause_i, clause_len_o=in_len_i for exactly one cycle; ptr++; num_loaded++.
  - in_ready_o is 1 in every LOAD cycle, so back-to-back beats give back-to-back wr pulses.
  - An accepted beat with in_last_i, or the beat that fills slot NUM_CLAUSES-1: if ptr+1<NUM_CLAUSES go to FILL, else go to FIN.
- FILL:
  - in_ready_o=0.
  - One slot per cycle: wr_o=1<<ptr, clause_o=0, clause_len_o=0; ptr++.
  - After slot NUM_CLAUSES-1 is written, go to FIN.
  - FILL does not change num_loaded.
- RD:
  - rd_o=1<<ptr for one cycle, then go to OUT.
  - On the cycle after rd_o is high, capture clause_i and clause_len_arr_i[ptr] into the out_* registers, set out_idx_o=ptr and raise out_valid_o.
- OUT:
  - Hold out_* stable while out_valid_o && !out_ready_i.
  - On the handshake: ptr++, drop out_valid_o. If ptr+1==num_loaded_o go to FIN, else go to RD.
  - Throughput is one beat per 3 cycles at most; no rd_o is issued while a beat is pending.
- FIN: done_o=1 for one cycle, then IDLE.
- wr_o and rd_o are never nonzero in the same cycle; at most one bit of either is set.
- Start pulses outside IDLE are ignored.
- in_valid_i outside LOAD is ignored (in_ready_o=0).
- Reset mid-pass aborts immediately:
  - A pending wr_o/rd_o pulse is dropped.
  - out_valid_o drops.
  - num_loaded_o returns to 0.
- Width rules:
  - ptr is $clog2(NUM_CLAUSES+1) bits and never exceeds NUM_CLAUSES.
  - out_idx_o is the truncated ptr.

Decomposition:
- Shared sat package:
  - state enum (IDLE, LOAD, FILL, RD, OUT, FIN).
  - Default NUM_VARS, NUM_CLAUSES and WIDTH_C_LEN values.
  - Width constants for ptr and out_idx_o.
- Sub-module onehot_dec (ptr plus enable to a NUM_CLAUSES-bit one-hot), shared by the wr_o and rd_o generation.

Test Plan:
1. Load 3 clauses, beat 3 with in_last=1, lens 2,3,1, data 16'h0009/16'h0126/16'h4000 -> wr_o pulses 01,02,04 on consecutive cycles carrying those data/len. FILL then writes slots 3..7 with zeros. done_o pulses once; num_loaded_o=3.
2. Load 8 beats with in_last=0 throughout -> wr_o walks 01..80, no FILL cycles, FIN after slot 7, in_ready_o=0 afterwards.
3. Unload after test 1, with array model lens {2,3,1} and out_ready stalled 4 cycles on beat 0 -> rd_o = 01,02,04 only. Beat 0 holds stable during the stall. out_idx_o = 0,1,2. Exactly 3 beats, then done_o.
4. Unload with clause_len_arr_i slot 1 = 0 (reason-locked) -> beat idx 1 has out_len_o=0 and its clause data is still returned.
5. load_start_i and unload_start_i in the same IDLE cycle -> LOAD entered. unload_start_i during LOAD is ignored.
6. Reset asserted in FILL at slot 5, and separately in OUT with out_valid_o=1 -> next cycle: state IDLE, wr_o=rd_o=0, out_valid_o=0, num_loaded_o=0, busy_o=0.
